// File: rtl/accelbrot_com_block_arbiter.sv
// Round-robin arbiter that grants one requester at a time and forwards exactly
// NWORDS words from its FWFT FIFO as a gapless, start-framed block to the
// word-to-block deserializer (which has no backpressure).
module accelbrot_com_block_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned NWORDS = 8,
  parameter int unsigned WWIDTH = 34
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NREQ-1:0]               req,
  input  logic [NREQ*WWIDTH-1:0]        in_data,
  output logic [NREQ-1:0]               pop,
  input  logic                          hold,
  output logic [WWIDTH-1:0]             out_word,
  output logic                          out_start,
  output logic                          out_valid,
  output logic [$clog2(NREQ)-1:0]       grant_id,
  output logic                          busy
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned CW  = $clog2(NWORDS);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [IDW-1:0]    sel;
  logic [IDW-1:0]    last;

  logic              pick_found;
  logic [IDW-1:0]    pick_idx;
  logic [IDW-1:0]    scan_idx;
  logic [WWIDTH-1:0] sel_word;

  // Round-robin search: first set req bit starting at last+1, wrapping at NREQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = last;
    for (int unsigned i = 0; i < NREQ; i++) begin
      scan_idx = (scan_idx == IDW'(NREQ - 1)) ? '0 : scan_idx + 1'b1;
      if (!pick_found && req[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  // Head word of the currently selected requester's FIFO.
  always_comb begin
    sel_word = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (sel == IDW'(k)) begin
        sel_word = in_data[k*WWIDTH +: WWIDTH];
      end
    end
  end

  // Grant FSM plus registered pop/status and output word pipeline.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      sel       <= '0;
      last      <= IDW'(NREQ - 1);
      pop       <= '0;
      busy      <= 1'b0;
      grant_id  <= '0;
      out_word  <= '0;
      out_start <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_start <= 1'b0;
      case (state)
        IDLE: begin
          if (!hold && pick_found) begin
            sel      <= pick_idx;
            grant_id <= pick_idx;
            cnt      <= '0;
            pop      <= NREQ'(1) << pick_idx;
            busy     <= 1'b1;
            state    <= BURST;
          end
        end
        BURST: begin
          // Word popped this cycle appears on the output one cycle later.
          out_word  <= sel_word;
          out_valid <= 1'b1;
          out_start <= (cnt == '0);
          if (cnt == CW'(NWORDS - 1)) begin
            last  <= sel;
            pop   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accelbrot_com_block_arbiter.sv
// Directed bench for accelbrot_com_block_arbiter: block framing, round robin,
// hold, req drop, mid-burst reset, and two small parameter sets.
module tb_accelbrot_com_block_arbiter;

  localparam int NR = 4;
  localparam int NW = 8;
  localparam int WW = 34;

  logic          clk = 1'b0;
  logic          rstn;
  logic          rstn_s;
  logic [NR-1:0] req;
  logic          hold;
  logic [NR*WW-1:0] in_data;
  logic [NR-1:0] pop;
  logic [WW-1:0] out_word;
  logic          out_start, out_valid, busy;
  logic [1:0]    grant_id;

  // sweep instance A: NREQ=2, NWORDS=2
  logic [1:0]      req_a;
  logic [2*WW-1:0] in_a;
  logic [1:0]      pop_a;
  logic [WW-1:0]   word_a;
  logic            start_a, valid_a, busy_a;
  logic [0:0]      gid_a;
  // sweep instance B: NREQ=5, NWORDS=3
  logic [4:0]      req_b;
  logic [5*WW-1:0] in_b;
  logic [4:0]      pop_b;
  logic [WW-1:0]   word_b;
  logic            start_b, valid_b, busy_b;
  logic [2:0]      gid_b;

  int ntests = 0;
  int nfail  = 0;

  logic [WW-1:0] base [NR];
  int npop [NR];
  int exp_cnt [NR];
  int npa [2];
  int npb [5];

  typedef struct {
    logic [NR-1:0] req;
    int            g;
  } vec_t;
  vec_t tbl [9];

  always #5 clk = ~clk;

  accelbrot_com_block_arbiter #(.NREQ(NR), .NWORDS(NW), .WWIDTH(WW)) u_dut (
    .clk(clk), .rstn(rstn), .req(req), .in_data(in_data), .pop(pop), .hold(hold),
    .out_word(out_word), .out_start(out_start), .out_valid(out_valid),
    .grant_id(grant_id), .busy(busy)
  );

  accelbrot_com_block_arbiter #(.NREQ(2), .NWORDS(2), .WWIDTH(WW)) u_a (
    .clk(clk), .rstn(rstn_s), .req(req_a), .in_data(in_a), .pop(pop_a), .hold(1'b0),
    .out_word(word_a), .out_start(start_a), .out_valid(valid_a),
    .grant_id(gid_a), .busy(busy_a)
  );

  accelbrot_com_block_arbiter #(.NREQ(5), .NWORDS(3), .WWIDTH(WW)) u_b (
    .clk(clk), .rstn(rstn_s), .req(req_b), .in_data(in_b), .pop(pop_b), .hold(1'b0),
    .out_word(word_b), .out_start(start_b), .out_valid(valid_b),
    .grant_id(gid_b), .busy(busy_b)
  );

  // FWFT FIFO models: head word = base + number of words already popped.
  always_comb begin
    for (int k = 0; k < NR; k++) in_data[k*WW +: WW] = base[k] + WW'(npop[k]);
    for (int k = 0; k < 2; k++)  in_a[k*WW +: WW] = WW'(k*256 + npa[k]);
    for (int k = 0; k < 5; k++)  in_b[k*WW +: WW] = WW'(k*256 + npb[k]);
  end

  always @(posedge clk) begin
    for (int k = 0; k < NR; k++) if (pop[k]) npop[k] <= npop[k] + 1;
    for (int k = 0; k < 2; k++)  if (pop_a[k]) npa[k] <= npa[k] + 1;
    for (int k = 0; k < 5; k++)  if (pop_b[k]) npb[k] <= npb[k] + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pop"},       64'(pop),       64'd0);
    check({tag, "_busy"},      64'(busy),      64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_start"}, 64'(out_start), 64'd0);
    check({tag, "_out_word"},  64'(out_word),  64'd0);
    check({tag, "_grant_id"},  64'(grant_id),  64'd0);
  endtask

  // Wait (bounded) at negedges until some pop is seen.
  task automatic wait_pop(input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pop == '0 && n < limit);
    check("wait_pop_timeout", 64'(pop != '0), 64'd1);
  endtask

  // Called at the negedge of the first pop cycle; leaves at the negedge two
  // cycles after the last pop (first pop of the next block if one is pending).
  task automatic check_block(input int g, input logic [NR-1:0] next_req, input logic next_hold);
    logic [WW-1:0] first;
    first = base[g] + WW'(exp_cnt[g]);
    for (int i = 0; i <= NW; i++) begin
      if (i < NW) begin
        check("blk_pop",      64'(pop),      64'(NR'(1) << g));
        check("blk_busy",     64'(busy),     64'd1);
        check("blk_grant_id", 64'(grant_id), 64'(g));
      end else begin
        check("blk_pop_end",  64'(pop),  64'd0);
        check("blk_busy_end", 64'(busy), 64'd0);
      end
      if (i == 0) begin
        check("blk_valid_pre", 64'(out_valid), 64'd0);
      end else begin
        check("blk_valid", 64'(out_valid), 64'd1);
        check("blk_start", 64'(out_start), 64'(i == 1));
        check("blk_word",  64'(out_word),  64'(first + WW'(i - 1)));
      end
      if (i == 1) req = next_req;
      if (i == 2) hold = next_hold;
      @(negedge clk);
    end
    exp_cnt[g] += NW;
  endtask

  // Closed-form expectation for the free-running all-requesting sweep.
  task automatic sweep_exp(input int c, input int nreq, input int nw,
                           output int epop, output int ev, output int es,
                           output int eword, output int egid);
    int q, b, p;
    q = c - 1; b = q / (nw + 1); p = q % (nw + 1);
    egid = b % nreq;
    epop = (p < nw) ? (1 << egid) : 0;
    ev = 0; es = 0; eword = 0;
    if (c >= 2) begin
      q = c - 2; b = q / (nw + 1); p = q % (nw + 1);
      ev = (p < nw) ? 1 : 0;
      es = (ev == 1 && p == 0) ? 1 : 0;
      eword = (b % nreq) * 256 + (b / nreq) * nw + p;
    end
  endtask

  initial begin
    int epop, ev, es, eword, egid;
    tbl[0] = '{4'b1111, 0};
    tbl[1] = '{4'b1111, 1};
    tbl[2] = '{4'b1111, 2};
    tbl[3] = '{4'b1111, 3};
    tbl[4] = '{4'b1111, 0};
    tbl[5] = '{4'b1010, 1};
    tbl[6] = '{4'b1010, 3};
    tbl[7] = '{4'b0110, 1};
    tbl[8] = '{4'b0001, 0};
    base[0] = 34'h0_0000_1000;
    base[1] = 34'h1_0000_2000;
    base[2] = 34'h0_0000_0010;
    base[3] = 34'h3_ABCD_0000;
    for (int k = 0; k < NR; k++) begin npop[k] = 0; exp_cnt[k] = 0; end
    for (int k = 0; k < 2; k++) npa[k] = 0;
    for (int k = 0; k < 5; k++) npb[k] = 0;
    rstn = 1'b0; rstn_s = 1'b0; req = '0; hold = 1'b0;
    req_a = 2'b11; req_b = 5'b11111;

    // reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // single request: requester 2, words 0x10..0x17
    rstn = 1'b1;
    req = 4'b0100;
    wait_pop(5);
    check_block(2, 4'b0000, 1'b0);

    // round robin / fairness table, starting from a fresh reset
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    req = tbl[0].req;
    wait_pop(5);
    for (int j = 0; j < 9; j++) begin
      check_block(tbl[j].g, (j + 1 < 9) ? tbl[j+1].req : 4'b0000, 1'b0);
    end

    // hold raised mid-burst: block completes, no new grant while held
    req = 4'b1111;
    wait_pop(5);
    check_block(1, 4'b1111, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("hold_pop",  64'(pop),  64'd0);
      check("hold_busy", 64'(busy), 64'd0);
      @(negedge clk);
    end
    hold = 1'b0;
    wait_pop(5);
    check_block(2, 4'b0000, 1'b0);

    // req drop by granted requester; late request from 3 waits for IDLE
    req = 4'b0010;
    wait_pop(5);
    check_block(1, 4'b1000, 1'b0);
    check_block(3, 4'b0000, 1'b0);

    // reset after three pops of requester 0
    req = 4'b1111;
    wait_pop(5);
    for (int i = 0; i < 3; i++) begin
      check("rst_mid_pop", 64'(pop), 64'd1);
      if (i < 2) @(negedge clk);
    end
    rstn = 1'b0;
    req = 4'b1010;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    exp_cnt[0] += 3;
    rstn = 1'b1;
    wait_pop(5);
    check_block(1, 4'b0000, 1'b0);

    // parameter sweep: both small instances free-running with all requests
    rstn_s = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      sweep_exp(c, 2, 2, epop, ev, es, eword, egid);
      check("a_pop",   64'(pop_a),   64'(epop));
      check("a_gid",   64'(gid_a),   64'(egid));
      check("a_valid", 64'(valid_a), 64'(ev));
      check("a_start", 64'(start_a), 64'(es));
      if (ev == 1) check("a_word", 64'(word_a), 64'(eword));
      sweep_exp(c, 5, 3, epop, ev, es, eword, egid);
      check("b_pop",   64'(pop_b),   64'(epop));
      check("b_gid",   64'(gid_b),   64'(egid));
      check("b_valid", 64'(valid_b), 64'(ev));
      check("b_start", 64'(start_b), 64'(es));
      if (ev == 1) check("b_word", 64'(word_b), 64'(eword));
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
